// File: rtl/game_start_ctrl.sv
// Session controller: consumes one credit per game start and sequences attract/request/play/game-over.
// Define GAME_START_CONTINUE_EN to allow a start press during game-over to request a new game directly.
module game_start_ctrl #(
    parameter int BLINK_FRAMES       = 30,
    parameter int REQ_TIMEOUT_FRAMES = 4,
    parameter int GAMEOVER_FRAMES    = 180
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       startKeyN,
    input  logic [3:0] credits,
    input  logic       gameOver,
    output logic       gameStart,
    output logic       gameActive,
    output logic       attractMode,
    output logic       blinkOn,
    output logic       gameOverShow,
    output logic [7:0] sessionCount
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_PLAYING,
        S_GAME_OVER
    } state_t;

    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
    localparam logic [7:0] REQ_LIMIT  = 8'(REQ_TIMEOUT_FRAMES);
    localparam logic [7:0] OVER_LAST  = 8'(GAMEOVER_FRAMES - 1);

    state_t     r_state;
    logic       r_start_prev;
    logic [7:0] r_frame_cnt;
    logic [3:0] r_cred_snap;
    logic       r_game_start;
    logic       r_game_active;
    logic       r_attract;
    logic       r_blink;
    logic       r_over_show;
    logic [7:0] r_session_cnt;

    logic       w_press;
    logic       w_has_credit;
    logic [7:0] w_cnt_inc;

    // Falling edge of the active-low key; r_start_prev resets low so a held key is not a press.
    assign w_press      = r_start_prev & ~startKeyN;
    assign w_has_credit = (credits != 4'd0);
    assign w_cnt_inc    = r_frame_cnt + 8'd1;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= S_IDLE;
            r_start_prev  <= 1'b0;
            r_frame_cnt   <= 8'd0;
            r_cred_snap   <= 4'd0;
            r_game_start  <= 1'b0;
            r_game_active <= 1'b0;
            r_attract     <= 1'b1;
            r_blink       <= 1'b0;
            r_over_show   <= 1'b0;
            r_session_cnt <= 8'd0;
        end else begin
            r_start_prev <= startKeyN;
            case (r_state)
                S_IDLE: begin
                    if (w_press && w_has_credit) begin
                        r_state      <= S_REQ;
                        r_frame_cnt  <= 8'd0;
                        r_cred_snap  <= credits;
                        r_game_start <= 1'b1;
                        r_attract    <= 1'b0;
                        r_blink      <= 1'b0;
                    end else if (w_has_credit) begin
                        r_blink     <= 1'b1;
                        r_frame_cnt <= 8'd0;
                    end else if (startOfFrame) begin
                        if (r_frame_cnt == BLINK_LAST) begin
                            r_blink     <= ~r_blink;
                            r_frame_cnt <= 8'd0;
                        end else begin
                            r_frame_cnt <= w_cnt_inc;
                        end
                    end
                end

                S_REQ: begin
                    // A coin inserted mid-request raises credits, so only a strict drop counts.
                    if (credits < r_cred_snap) begin
                        r_state       <= S_PLAYING;
                        r_frame_cnt   <= 8'd0;
                        r_game_start  <= 1'b0;
                        r_game_active <= 1'b1;
                        if (r_session_cnt != 8'hFF) begin
                            r_session_cnt <= r_session_cnt + 8'd1;
                        end
                    end else if (r_frame_cnt == REQ_LIMIT) begin
                        r_state      <= S_IDLE;
                        r_frame_cnt  <= 8'd0;
                        r_game_start <= 1'b0;
                        r_attract    <= 1'b1;
                    end else if (startOfFrame) begin
                        r_frame_cnt <= w_cnt_inc;
                    end
                end

                S_PLAYING: begin
                    if (gameOver) begin
                        r_state       <= S_GAME_OVER;
                        r_frame_cnt   <= 8'd0;
                        r_game_active <= 1'b0;
                        r_over_show   <= 1'b1;
                    end else if (startOfFrame) begin
                        r_frame_cnt <= w_cnt_inc;
                    end
                end

                S_GAME_OVER: begin
`ifdef GAME_START_CONTINUE_EN
                    if (w_press && w_has_credit) begin
                        r_state      <= S_REQ;
                        r_frame_cnt  <= 8'd0;
                        r_cred_snap  <= credits;
                        r_game_start <= 1'b1;
                        r_over_show  <= 1'b0;
                    end else
`endif
                    if (startOfFrame) begin
                        if (r_frame_cnt == OVER_LAST) begin
                            r_state     <= S_IDLE;
                            r_frame_cnt <= 8'd0;
                            r_over_show <= 1'b0;
                            r_attract   <= 1'b1;
                        end else begin
                            r_frame_cnt <= w_cnt_inc;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gameStart    = r_game_start;
    assign gameActive   = r_game_active;
    assign attractMode  = r_attract;
    assign blinkOn      = r_blink;
    assign gameOverShow = r_over_show;
    assign sessionCount = r_session_cnt;

endmodule

// File: tb/tb_game_start_ctrl.sv
// Randomized bench for game_start_ctrl: the bench plays the credit counter and compares every
// cycle against a phase-level model of the session rules.
module tb_game_start_ctrl;

    localparam int BLINK_FRAMES       = 30;
    localparam int REQ_TIMEOUT_FRAMES = 4;
    localparam int GAMEOVER_FRAMES    = 180;
    localparam int FRAME_LEN          = 4;

    localparam int PH_ATTRACT = 0;
    localparam int PH_REQ     = 1;
    localparam int PH_PLAY    = 2;
    localparam int PH_OVER    = 3;

    logic       clk          = 1'b0;
    logic       resetN       = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       startKeyN    = 1'b1;
    logic [3:0] credits      = 4'd0;
    logic       gameOver     = 1'b0;
    logic       gameStart;
    logic       gameActive;
    logic       attractMode;
    logic       blinkOn;
    logic       gameOverShow;
    logic [7:0] sessionCount;

    int n_total = 0;
    int n_bad   = 0;

    // model state
    int m_phase    = PH_ATTRACT;
    int m_frames   = 0;
    int m_sessions = 0;
    int m_snap     = 0;
    bit m_blink    = 1'b0;
    bit m_prev_key = 1'b0;

    // environment state
    int cyc         = 0;
    int pend_dec    = -1;
    int force_delay = -2;
    bit coins_en    = 1'b0;
    int n_async     = 0;
    int exp_sessions = 1;

    always #5 clk = ~clk;

    game_start_ctrl #(
        .BLINK_FRAMES      (BLINK_FRAMES),
        .REQ_TIMEOUT_FRAMES(REQ_TIMEOUT_FRAMES),
        .GAMEOVER_FRAMES   (GAMEOVER_FRAMES)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .startKeyN   (startKeyN),
        .credits     (credits),
        .gameOver    (gameOver),
        .gameStart   (gameStart),
        .gameActive  (gameActive),
        .attractMode (attractMode),
        .blinkOn     (blinkOn),
        .gameOverShow(gameOverShow),
        .sessionCount(sessionCount)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase    = PH_ATTRACT;
        m_frames   = 0;
        m_sessions = 0;
        m_snap     = 0;
        m_blink    = 1'b0;
        m_prev_key = 1'b0;
    endtask

    // The credit counter answers a new request after a chosen or random delay, or never.
    task automatic enter_req();
        int r;
        m_phase  = PH_REQ;
        m_frames = 0;
        m_snap   = int'(credits);
        m_blink  = 1'b0;
        if (force_delay != -2) begin
            pend_dec = force_delay;
        end else begin
            r = $urandom_range(0, 9);
            if (r < 6)      pend_dec = $urandom_range(1, 6);
            else if (r < 8) pend_dec = $urandom_range(12, 26);
            else            pend_dec = -1;
        end
    endtask

    task automatic model_clock();
        bit press;
        if (!resetN) begin
            model_reset();
            return;
        end
        press      = m_prev_key && !startKeyN;
        m_prev_key = startKeyN;
        case (m_phase)
            PH_ATTRACT: begin
                if (press && credits != 0) begin
                    enter_req();
                end else if (credits != 0) begin
                    m_blink  = 1'b1;
                    m_frames = 0;
                end else if (startOfFrame) begin
                    m_frames++;
                    if (m_frames == BLINK_FRAMES) begin
                        m_blink  = !m_blink;
                        m_frames = 0;
                    end
                end
            end
            PH_REQ: begin
                if (int'(credits) < m_snap) begin
                    m_phase  = PH_PLAY;
                    m_frames = 0;
                    if (m_sessions < 255) m_sessions++;
                end else if (m_frames >= REQ_TIMEOUT_FRAMES) begin
                    m_phase  = PH_ATTRACT;
                    m_frames = 0;
                end else if (startOfFrame) begin
                    m_frames++;
                end
            end
            PH_PLAY: begin
                if (gameOver) begin
                    m_phase  = PH_OVER;
                    m_frames = 0;
                end
            end
            default: begin
`ifdef GAME_START_CONTINUE_EN
                if (press && credits != 0) begin
                    enter_req();
                end else
`endif
                if (startOfFrame) begin
                    m_frames++;
                    if (m_frames == GAMEOVER_FRAMES) begin
                        m_phase  = PH_ATTRACT;
                        m_frames = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        check_eq("gameStart",    gameStart,    32'(m_phase == PH_REQ));
        check_eq("gameActive",   gameActive,   32'(m_phase == PH_PLAY));
        check_eq("attractMode",  attractMode,  32'(m_phase == PH_ATTRACT));
        check_eq("gameOverShow", gameOverShow, 32'(m_phase == PH_OVER));
        check_eq("blinkOn",      blinkOn,      32'(m_blink));
        check_eq("sessionCount", sessionCount, 32'(m_sessions));
        cyc++;
        startOfFrame = ((cyc % FRAME_LEN) == FRAME_LEN - 1);
        gameOver     = 1'b0;
        if (pend_dec > 0) begin
            pend_dec--;
            if (pend_dec == 0) begin
                if (credits != 0) credits = credits - 4'd1;
                pend_dec = -1;
            end
        end
        if (coins_en && credits < 5 && $urandom_range(0, 249) == 0) credits = credits + 4'd1;
    endtask

    task automatic press_key();
        startKeyN = 1'b1;
        step();
        startKeyN = 1'b0;
        step();
    endtask

    task automatic wait_attract(input int limit);
        int n = 0;
        while (attractMode !== 1'b1 && n < limit) begin
            gameOver = (gameActive === 1'b1);
            step();
            n++;
        end
        check_eq("reach_attract", attractMode, 1);
    endtask

    task automatic async_reset_check();
        resetN = 1'b0;
        #1;
        check_eq("async_drop_start", gameStart, 0);
        check_eq("async_attract", attractMode, 1);
        check_eq("async_sessions", sessionCount, 0);
        model_reset();
        pend_dec = -1;
        step();
        step();
        resetN = 1'b1;
        n_async++;
    endtask

    initial begin
        int n;
        int toggles;
        bit last_blink;

        // key held low through reset must not start a game
        resetN      = 1'b0;
        startKeyN   = 1'b0;
        credits     = 4'd2;
        repeat (3) step();
        resetN = 1'b1;
        repeat (6) step();
        check_eq("held_key_no_start", gameStart, 0);

        credits     = 4'd3;
        force_delay = 3;
        press_key();
        check_eq("press_starts_req", gameStart, 1);
        check_eq("req_clears_attract", attractMode, 0);
        repeat (2) step();
        check_eq("req_holds_start", gameStart, 1);
        step();
        check_eq("play_active", gameActive, 1);
        check_eq("play_start_low", gameStart, 0);
        check_eq("play_sessions", sessionCount, 1);

        gameOver = 1'b1;
        step();
        check_eq("over_show", gameOverShow, 1);
        check_eq("over_inactive", gameActive, 0);
        repeat (10) step();
        force_delay = 2;
        press_key();
`ifdef GAME_START_CONTINUE_EN
        check_eq("continue_req", gameStart, 1);
        check_eq("continue_hides_banner", gameOverShow, 0);
        exp_sessions = 2;
`else
        check_eq("over_press_ignored", gameStart, 0);
        check_eq("over_banner_kept", gameOverShow, 1);
`endif
        wait_attract(1500);
        check_eq("sessions_after_over", sessionCount, 32'(exp_sessions));

        // zero credits: press ignored, blink toggles every BLINK_FRAMES frames
        credits    = 4'd0;
        toggles    = 0;
        last_blink = blinkOn;
        for (int i = 0; i < 75 * FRAME_LEN; i++) begin
            if (i == 10) startKeyN = 1'b1;
            if (i == 11) startKeyN = 1'b0;
            step();
            if (i == 11) begin
                check_eq("zero_credit_press_ignored", gameStart, 0);
                check_eq("zero_credit_stays_attract", attractMode, 1);
            end
            if (blinkOn !== last_blink) toggles++;
            last_blink = blinkOn;
        end
        check_eq("blink_toggles", toggles, 2);

        // request never answered
        credits     = 4'd1;
        force_delay = -1;
        press_key();
        check_eq("timeout_req_start", gameStart, 1);
        n = 0;
        while (gameStart === 1'b1 && n < 40) begin
            step();
            n++;
        end
        check_eq("timeout_drop", gameStart, 0);
        check_eq("timeout_attract", attractMode, 1);
        check_eq("timeout_no_session", sessionCount, 32'(exp_sessions));

        // reset mid-request
        credits = 4'd2;
        press_key();
        async_reset_check();

        force_delay = -2;
        coins_en    = 1'b1;
        for (int i = 0; i < 16000; i++) begin
            if ($urandom_range(0, 11) == 0) startKeyN = ~startKeyN;
            gameOver = ($urandom_range(0, 59) == 0);
            step();
            if (m_phase == PH_REQ && n_async < 5 && $urandom_range(0, 3) == 0) async_reset_check();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/game_start_ctrl.md
Name: game_start_ctrl

Overview:
- Consumer end of the credit interface. Watches the `credits` count from the coin/credit counter.
- On a start-key press with `credits`>0, raises `gameStart` and holds it until the counter's decrement is seen.
- Then runs the session state: attract → request → playing → game-over.
- Also drives the "insert coin" blink and the game-over banner enable for the drawing pipeline.

Parameters:
- BLINK_FRAMES, 30, frames per half-period of `blinkOn` in attract mode.
- REQ_TIMEOUT_FRAMES, 4, frames to wait in REQ for a credit decrement before aborting.
- GAMEOVER_FRAMES, 180, frames the game-over banner is shown.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per video frame
- startKeyN  in  1  start key, active-low level (0 = pressed)
- credits  in  4  current credit count from the credit counter (0..5)
- gameOver  in  1  one-cycle pulse from game logic: last life lost
- gameStart  out  1  credit-consume request, level; credit counter decrements once per rising edge
- gameActive  out  1  high while in PLAYING
- attractMode  out  1  high while in IDLE
- blinkOn  out  1  "insert coin" text enable
- gameOverShow  out  1  game-over banner enable
- sessionCount  out  8  number of games started since reset, saturating at 255

Behaviour:
- Reset: clk and resetN as named above; resetN is asynchronous, active-low.
  - Outputs on reset: state=IDLE, gameStart=0, gameActive=0, attractMode=1, blinkOn=0, gameOverShow=0, sessionCount=0.
  - Internal on reset: frame counters=0, startPrev=0.
- Start detection:
  - startPrev registers startKeyN every clk.
  - press = startPrev==1 && startKeyN==0.
  - startPrev resets to 0, so a key held through reset never produces a press.
- Frame counter:
  - One shared counter, 8 bits, advanced only on startOfFrame.
  - Cleared on every state transition.
- IDLE:
  - attractMode=1.
  - If credits==0: blinkOn toggles each time the counter reaches BLINK_FRAMES-1 (counter then clears).
  - If credits>0: blinkOn=1 steady.
  - press with credits>0 → REQ. Same clock edge: credSnap<=credits, gameStart<=1, attractMode<=0, blinkOn<=0.
  - press with credits==0 is ignored.
- REQ:
  - gameStart held at 1.
  - If credits<credSnap → PLAYING. Same edge: gameStart<=0, gameActive<=1, sessionCount<=sessionCount+1 (saturating).
  - Else, if the counter reaches REQ_TIMEOUT_FRAMES → IDLE with gameStart<=0 and no session counted.
  - Decrement check has priority over timeout when both occur in the same cycle.
  - gameOver is ignored in REQ.
  - gameStart is always low for at least one cycle between requests; this re-arms the counter.
- PLAYING:
  - gameActive=1.
  - gameOver pulse → GAME_OVER. Same edge: gameActive<=0, gameOverShow<=1.
  - press is ignored.
- GAME_OVER:
  - gameOverShow=1.
  - When the counter reaches GAMEOVER_FRAMES-1 on startOfFrame → IDLE. Same edge: gameOverShow<=0, attractMode<=1.
  - press is ignored (unless the optional feature below is compiled in).
- Boundaries:
  - credits changing upward (coin insert) during REQ does not satisfy the decrement check.
  - The check is strictly credits<credSnap.
  - resetN low in any state immediately forces the reset values, including dropping gameStart mid-request.
- Latency: all outputs are registered. Each transition and its output updates take effect on the same clk edge as the triggering condition.

Optional Feature:
- Macro GAME_START_CONTINUE_EN.
- Defined: in GAME_OVER, press with credits>0 → REQ immediately. Same edge: gameOverShow<=0, credSnap<=credits, gameStart<=1.
  - This allows a continue without passing through attract.
  - A continue that succeeds still increments sessionCount.
- Not defined: press in GAME_OVER is ignored.

Test Plan:
- Reset with startKeyN=0 held, credits=2, then release and press → exactly one REQ entry. No press is detected during or immediately after reset.
- credits=0, press in IDLE → stays IDLE, gameStart=0. blinkOn toggles every 30 frames (BLINK_FRAMES=30).
- credits=3, press → gameStart=1 next edge. Credits drops to 2 three cycles later → PLAYING on that edge, gameStart=0, gameActive=1, sessionCount=1.
- credits=1, press, credits never decrements → gameStart drops and state returns to IDLE after 4 startOfFrame pulses. sessionCount unchanged.
- In PLAYING, pulse gameOver → gameOverShow=1 for 180 frames, then attractMode=1. A press during GAME_OVER is ignored (macro off), or leads to REQ with credits=2 (macro on).
- In REQ with gameStart=1, assert resetN=0 → gameStart=0 and attractMode=1 asynchronously; credits are not consumed.
